// File: rtl/f2f_cmd_packer.sv
// f2f_cmd_packer: frames one conversion request as a header word plus one or
// two payload words and writes them into the converter's 48-bit input FIFO,
// stalling on fifo_full without dropping or repeating any word.
module f2f_cmd_packer #(
   parameter logic [3:0] SYNC_HDR = 4'hA,
   parameter logic [3:0] SYNC_PAY = 4'h5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_app,
   input  logic [2:0]  req_size,
   input  logic [79:0] req_data,
   input  logic        fifo_full,
   output logic        fifo_wren,
   output logic [47:0] fifo_din,
   output logic        err,
   output logic [15:0] tag
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_PAY0 = 2'd2;
   localparam logic [1:0] S_PAY1 = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [1:0]  app_cap;
   logic [2:0]  size_cap;
   logic [79:0] data_cap;
   logic [15:0] tag_cnt;
   logic [15:0] tag_nxt;
   logic        err_reg;
   logic        accept;
   logic        legal;
   logic [39:0] chunk0;
   logic [39:0] chunk1;

   // A request is legal only for the two defined directions and three sizes.
   assign legal     = !req_app[1] &&
                      ((req_size == 3'b001) || (req_size == 3'b010) || (req_size == 3'b011));
   assign accept    = (state == S_IDLE) && req_valid;
   assign req_ready = (state == S_IDLE);
   // Every non-idle state has exactly one word pending; it goes out when the FIFO has room.
   assign fifo_wren = (state != S_IDLE) && !fifo_full;
   assign err       = err_reg;
   assign tag       = tag_cnt;

   // Split the captured operand into the 40-bit payload fields.
   always_comb begin
      chunk0 = {8'h00, data_cap[31:0]};
      chunk1 = {8'h00, data_cap[31:0]};
      case (size_cap)
         3'b010: chunk0 = {8'h00, data_cap[63:32]};
         3'b011: begin
            chunk0 = data_cap[79:40];
            chunk1 = data_cap[39:0];
         end
         default: ;
      endcase
   end

   // Select the word presented to the FIFO; it depends only on state and captured fields.
   always_comb begin
      fifo_din = '0;
      case (state)
         S_HDR:   fifo_din = {SYNC_HDR, app_cap, size_cap, 23'h0, tag_cnt};
         S_PAY0:  fifo_din = {SYNC_PAY, 4'h0, chunk0};
         S_PAY1:  fifo_din = {SYNC_PAY, 4'h1, chunk1};
         default: ;
      endcase
   end

   // Advance the frame only on an edge where the current word is written.
   always_comb begin
      state_nxt = state;
      tag_nxt   = tag_cnt;
      case (state)
         S_IDLE: if (accept && legal) state_nxt = S_HDR;
         S_HDR: if (fifo_wren) begin
            state_nxt = S_PAY0;
            tag_nxt   = tag_cnt + 16'd1;
         end
         S_PAY0: if (fifo_wren) state_nxt = (size_cap == 3'b001) ? S_IDLE : S_PAY1;
         S_PAY1: if (fifo_wren) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control state: frame position, tag counter and the illegal-request pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         tag_cnt <= '0;
         err_reg <= 1'b0;
      end else begin
         state   <= state_nxt;
         tag_cnt <= tag_nxt;
         err_reg <= accept && !legal;
      end
   end

   // Operand capture; held unchanged for the whole frame since accept only fires in idle.
   always_ff @(posedge clk) begin
      if (accept) begin
         app_cap  <= req_app;
         size_cap <= req_size;
         data_cap <= req_data;
      end
   end

endmodule
